sobel_out_packer: RTL and testbench

- Drains the 8-bit Sobel output FIFO of the image pipeline (the reader end of its rd_en/empty/dout interface).
- Tracks column and row position in the frame and packs up to 4 pixels per 32-bit word.
- Emits words on a valid/ready stream with sof/eol/eof markers for the downstream DMA/host writer.
- Rows never share a word; a row tail is flushed as a partial word with byte keep.

---
 rtl/sobel_out_packer.sv | 200 ++++++++++++++++++++
 tb/tb_sobel_out_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_out_packer.sv
// Drains the Sobel output FIFO and packs up to four pixels per 32-bit stream word with sof/eol/eof
// markers. Define SOBEL_PACK_THRESH_EN to add the thresh port and binarise each pixel before packing.
module sobel_out_packer #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 in_rd_en,
  input  logic                 in_empty,
  input  logic [7:0]           in_dout,
`ifdef SOBEL_PACK_THRESH_EN
  input  logic [7:0]           thresh,
`endif
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_data,
  output logic [3:0]           m_keep,
  output logic                 m_sof,
  output logic                 m_eol,
  output logic                 m_eof,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 busy
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  function automatic logic [3:0] keep_of(input logic [1:0] lane);
    case (lane)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

`ifdef SOBEL_PACK_THRESH_EN
  function automatic logic [7:0] binarise(input logic [7:0] px, input logic [7:0] th);
    return (px >= th) ? 8'hFF : 8'h00;
  endfunction
`endif

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [1:0]             lane_q, lane_d;
  logic [31:0]            asm_q, asm_d;
  logic                   wsof_q, wsof_d;
  logic                   inflight_q;
  logic                   pend_q, pend_d;
  logic [3:0]             pkeep_q, pkeep_d;
  logic                   psof_q, psof_d, peol_q, peol_d, peof_q, peof_d;
  logic                   out_vld_q, out_vld_d;
  logic [31:0]            out_data_q, out_data_d;
  logic [3:0]             out_keep_q, out_keep_d;
  logic                   out_sof_q, out_sof_d, out_eol_q, out_eol_d, out_eof_q, out_eof_d;
  logic [CNT_WIDTH-1:0]   fc_q, fc_d;

  logic [7:0]  byte_in;
  logic        at_eol, at_eof, done_now, hs, out_free, stall, load;
  logic [31:0] new_data;
  logic        new_sof;

`ifdef SOBEL_PACK_THRESH_EN
  assign byte_in = binarise(in_dout, thresh);
`else
  assign byte_in = in_dout;
`endif

  // The byte arriving this cycle belongs at (col_q,row_q) in lane lane_q.
  assign at_eol   = (col_q == COL_LAST);
  assign at_eof   = at_eol && (row_q == ROW_LAST);
  assign done_now = inflight_q && ((lane_q == 2'd3) || at_eol);
  assign hs       = out_vld_q && m_ready;
  assign out_free = !out_vld_q || m_ready;
  assign stall    = pend_q || (done_now && out_vld_q && !m_ready);
  assign load     = (pend_q || done_now) && out_free;
  assign in_rd_en = rst && !in_empty && !stall;
  assign new_data = asm_q | (32'(byte_in) << {lane_q, 3'b000});
  assign new_sof  = (lane_q == 2'd0) ? ((col_q == '0) && (row_q == '0)) : wsof_q;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    wsof_d     = wsof_q;
    pend_d     = pend_q;
    pkeep_d    = pkeep_q;
    psof_d     = psof_q;
    peol_d     = peol_q;
    peof_d     = peof_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_sof_d  = out_sof_q;
    out_eol_d  = out_eol_q;
    out_eof_d  = out_eof_q;
    fc_d       = fc_q;

    if (inflight_q) begin
      asm_d  = new_data;
      wsof_d = new_sof;
      if (at_eol) begin
        col_d  = '0;
        lane_d = 2'd0;
        row_d  = at_eof ? '0 : row_q + RW'(1);
      end else begin
        col_d  = col_q + CW'(1);
        lane_d = lane_q + 2'd1;
      end
    end

    // A finished word either goes straight to the output register or parks in the
    // assembly register; reads stay stalled while it is parked.
    if (done_now) begin
      if (out_free) begin
        asm_d = '0;
      end else begin
        pend_d  = 1'b1;
        pkeep_d = keep_of(lane_q);
        psof_d  = new_sof;
        peol_d  = at_eol;
        peof_d  = at_eof;
      end
    end
    if (pend_q && out_free) begin
      pend_d = 1'b0;
      asm_d  = '0;
    end

    if (load) begin
      out_vld_d  = 1'b1;
      out_data_d = pend_q ? asm_q   : new_data;
      out_keep_d = pend_q ? pkeep_q : keep_of(lane_q);
      out_sof_d  = pend_q ? psof_q  : new_sof;
      out_eol_d  = pend_q ? peol_q  : at_eol;
      out_eof_d  = pend_q ? peof_q  : at_eof;
    end else if (hs) begin
      out_vld_d = 1'b0;
    end

    if (hs && out_eof_q) fc_d = fc_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      row_q      <= '0;
      lane_q     <= '0;
      asm_q      <= '0;
      wsof_q     <= 1'b0;
      inflight_q <= 1'b0;
      pend_q     <= 1'b0;
      pkeep_q    <= '0;
      psof_q     <= 1'b0;
      peol_q     <= 1'b0;
      peof_q     <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_sof_q  <= 1'b0;
      out_eol_q  <= 1'b0;
      out_eof_q  <= 1'b0;
      fc_q       <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      wsof_q     <= wsof_d;
      inflight_q <= in_rd_en;
      pend_q     <= pend_d;
      pkeep_q    <= pkeep_d;
      psof_q     <= psof_d;
      peol_q     <= peol_d;
      peof_q     <= peof_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_sof_q  <= out_sof_d;
      out_eol_q  <= out_eol_d;
      out_eof_q  <= out_eof_d;
      fc_q       <= fc_d;
    end
  end

  assign m_valid     = out_vld_q;
  assign m_data      = out_data_q;
  assign m_keep      = out_keep_q;
  assign m_sof       = out_sof_q;
  assign m_eol       = out_eol_q;
  assign m_eof       = out_eof_q;
  assign frame_count = fc_q;
  assign busy        = inflight_q || (lane_q != 2'd0) || pend_q || out_vld_q;

endmodule

// File: tb/tb_sobel_out_packer.sv
// Bench for sobel_out_packer: a 6x2 instance and a 1x1 instance, each fed by a FIFO model and
// compared against a row-chunking reference model of the packed stream.
module tb_sobel_out_packer;

  localparam int W0 = 6;
  localparam int H0 = 2;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        s;
    logic        l;
    logic        f;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic m_ready;
`ifdef SOBEL_PACK_THRESH_EN
  logic [7:0] thresh;
`endif

  logic       rd0, rd1;
  logic       empty0 = 1'b1, empty1 = 1'b1;
  logic [7:0] dout0 = 8'h00, dout1 = 8'h00;
  logic       vld0, vld1, sof0, sof1, eol0, eol1, eof0, eof1, busy0, busy1;
  logic [31:0] data0, data1;
  logic [3:0] keep0, keep1, fc0, fc1;

  sobel_out_packer #(.IMG_WIDTH(W0), .IMG_HEIGHT(H0), .CNT_WIDTH(4)) dut0 (
    .clk(clk), .rst(rst), .in_rd_en(rd0), .in_empty(empty0), .in_dout(dout0),
`ifdef SOBEL_PACK_THRESH_EN
    .thresh(thresh),
`endif
    .m_valid(vld0), .m_ready(m_ready), .m_data(data0), .m_keep(keep0), .m_sof(sof0),
    .m_eol(eol0), .m_eof(eof0), .frame_count(fc0), .busy(busy0));

  sobel_out_packer #(.IMG_WIDTH(1), .IMG_HEIGHT(1), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .in_rd_en(rd1), .in_empty(empty1), .in_dout(dout1),
`ifdef SOBEL_PACK_THRESH_EN
    .thresh(thresh),
`endif
    .m_valid(vld1), .m_ready(m_ready), .m_data(data1), .m_keep(keep1), .m_sof(sof1),
    .m_eol(eol1), .m_eof(eof1), .frame_count(fc1), .busy(busy1));

  int nchecks = 0;
  int nerr = 0;

  logic [7:0] fifo0[$];
  logic [7:0] px0[$];
  logic [7:0] sent1[$];
  word_t      got0[$], got1[$], expq[$];
  bit         gap_en = 1'b0, gap_ph = 1'b0;
  int unsigned reads1 = 0, lim1 = 0;
  bit         rd_bad = 1'b0, stab_bad = 1'b0, held0 = 1'b0;
  word_t      hold0, cur0, cur1;

  assign cur0 = {data0, keep0, sof0, eol0, eof0};
  assign cur1 = {data1, keep1, sof1, eol1, eof1};

  function automatic logic [7:0] pix(input logic [7:0] b);
`ifdef SOBEL_PACK_THRESH_EN
    return (b >= thresh) ? 8'hFF : 8'h00;
`else
    return b;
`endif
  endfunction

  // FIFO models: data appears on dout the cycle after an accepted read.
  always @(posedge clk) begin : fifo0_model
    logic [7:0] t;
    if (rd0 && !empty0) begin
      t = fifo0.pop_front();
      dout0 <= t;
    end
    empty0 <= (fifo0.size() == 0) || (gap_en && !gap_ph);
    gap_ph <= ~gap_ph;
  end

  always @(posedge clk) begin : fifo1_model
    logic [7:0] t;
    int unsigned r;
    r = reads1;
    if (rd1 && !empty1) begin
      t = 8'($urandom);
      dout1 <= t;
      sent1.push_back(pix(t));
      r = r + 1;
    end
    reads1 <= r;
    empty1 <= (r >= lim1);
  end

  always @(negedge clk) begin
    if (rst && vld0 && m_ready) got0.push_back(cur0);
    if (rst && vld1 && m_ready) got1.push_back(cur1);
    if ((rd0 && empty0) || (rd1 && empty1)) rd_bad <= 1'b1;
    if (rst && held0 && !(vld0 && cur0 == hold0)) stab_bad <= 1'b1;
    held0 <= rst && vld0 && !m_ready;
    hold0 <= cur0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every row is cut into 4-pixel chunks from column 0; the last chunk may be short.
  task automatic build_exp(input logic [7:0] px[$], input int w, input int h);
    int p, pos, r, c, n;
    word_t e;
    expq.delete();
    p = 0;
    while (p < px.size()) begin
      pos = p % (w * h);
      r = pos / w;
      c = pos % w;
      n = (w - c < 4) ? (w - c) : 4;
      if (p + n > px.size()) break;
      e = '0;
      for (int k = 0; k < n; k++) e.d[8*k +: 8] = px[p + k];
      e.k = 4'((1 << n) - 1);
      e.s = (pos == 0);
      e.l = (c + n == w);
      e.f = e.l && (r == h - 1);
      expq.push_back(e);
      p += n;
    end
  endtask

  task automatic cmp_words(input string tag, input word_t g[$], input int from);
    chk({tag, ".count"}, 64'(g.size()), 64'(expq.size()));
    for (int i = from; i < expq.size(); i++)
      if (i < g.size()) chk($sformatf("%s.w%0d", tag, i), 64'(g[i]), 64'(expq[i]));
  endtask

  task automatic push0(input logic [7:0] b);
    fifo0.push_back(b);
    px0.push_back(pix(b));
  endtask

  task automatic wait_got0(input int n, input int budget, input bit rnd);
    int c;
    c = 0;
    while (got0.size() < n && c < budget) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick(1);
      c++;
    end
    m_ready = 1'b1;
  endtask

  initial begin
    int c;
    rst = 1'b0;
    m_ready = 1'b0;
`ifdef SOBEL_PACK_THRESH_EN
    thresh = 8'h06;
`endif
    for (int i = 1; i <= 12; i++) push0(8'(i));
    tick(3);

    // Reset state, with the FIFO already non-empty.
    chk("rst.rd_en", 64'(rd0), 64'(0));
    chk("rst.valid", 64'(vld0), 64'(0));
    chk("rst.data", 64'(data0), 64'(0));
    chk("rst.keep", 64'(keep0), 64'(0));
    chk("rst.sof", 64'(sof0), 64'(0));
    chk("rst.eol", 64'(eol0), 64'(0));
    chk("rst.eof", 64'(eof0), 64'(0));
    chk("rst.frame_count", 64'(fc0), 64'(0));
    chk("rst.busy", 64'(busy0), 64'(0));
    chk("rst1.valid", 64'(vld1), 64'(0));
    chk("rst1.frame_count", 64'(fc1), 64'(0));
    chk("rst1.busy", 64'(busy1), 64'(0));

    // Frame 1, ready held high.
    rst = 1'b1;
    m_ready = 1'b1;
    wait_got0(4, 100, 1'b0);
    build_exp(px0, W0, H0);
    cmp_words("t1", got0, 0);
`ifndef SOBEL_PACK_THRESH_EN
    chk("t1.w0.const", 64'(got0[0].d), 64'h04030201);
    chk("t1.w3.const", 64'(got0[3].d), 64'h00000C0B);
`endif
    chk("t1.frame_count", 64'(fc0), 64'(1));
    tick(3);
    chk("t1.idle_busy", 64'(busy0), 64'(0));

    // Frame 2 with downstream stalled: word 0 sits in the output register and the
    // two-pixel row tail parks in assembly, so 6 of 12 bytes remain in the FIFO.
    m_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push0(8'(i));
    build_exp(px0, W0, H0);
    tick(20);
    chk("t2.stall_valid", 64'(vld0), 64'(1));
    chk("t2.stall_word", 64'(cur0), 64'(expq[4]));
    chk("t2.stall_rd_en", 64'(rd0), 64'(0));
    chk("t2.fifo_left", 64'(fifo0.size()), 64'(6));
    chk("t2.stall_busy", 64'(busy0), 64'(1));
    m_ready = 1'b1;
    wait_got0(8, 100, 1'b0);
    cmp_words("t2", got0, 4);
    chk("t2.frame_count", 64'(fc0), 64'(2));

    // Two random frames, FIFO empty every other cycle, random backpressure.
    gap_en = 1'b1;
    for (int i = 0; i < 24; i++) push0(8'($urandom));
    wait_got0(16, 600, 1'b1);
    gap_en = 1'b0;
    build_exp(px0, W0, H0);
    cmp_words("t3", got0, 8);
    chk("t3.frame_count", 64'(fc0), 64'(4));

    // Asynchronous reset mid-frame while a word waits in the output register.
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push0(8'($urandom));
    c = 0;
    while (!vld0 && c < 50) begin tick(1); c++; end
    chk("t4.pre_valid", 64'(vld0), 64'(1));
    tick(2);
    rst = 1'b0;
    #1;
    chk("t4.valid", 64'(vld0), 64'(0));
    chk("t4.data", 64'(data0), 64'(0));
    chk("t4.busy", 64'(busy0), 64'(0));
    chk("t4.frame_count", 64'(fc0), 64'(0));
    chk("t4.rd_en", 64'(rd0), 64'(0));
    fifo0.delete();
    px0.delete();
    got0.delete();
    tick(3);
    for (int i = 0; i < 12; i++) push0(8'($urandom));
    rst = 1'b1;
    m_ready = 1'b1;
    wait_got0(4, 100, 1'b0);
    build_exp(px0, W0, H0);
    cmp_words("t4", got0, 0);
    chk("t4.sof", 64'(got0[0].s), 64'(1));
    chk("t4.frame_count_after", 64'(fc0), 64'(1));

    // 16 more 6x2 frames and 17 1x1 frames: both counters wrap to 1.
    for (int i = 0; i < 16 * 12; i++) push0(8'($urandom));
    lim1 = 17;
    c = 0;
    while ((got0.size() < 68 || got1.size() < 17) && c < 3000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick(1);
      c++;
    end
    m_ready = 1'b1;
    tick(5);
    build_exp(px0, W0, H0);
    cmp_words("t5", got0, 4);
    chk("t5.frame_count", 64'(fc0), 64'(1));
    build_exp(sent1, 1, 1);
    cmp_words("t5x1", got1, 0);
    chk("t5x1.frame_count", 64'(fc1), 64'(1));
    chk("t5x1.keep", 64'(got1[16].k), 64'(4'b0001));

`ifdef SOBEL_PACK_THRESH_EN
    thresh = 8'h80;
    push0(8'h7F); push0(8'h80); push0(8'h00); push0(8'hFF);
    for (int i = 0; i < 8; i++) push0(8'($urandom));
    wait_got0(72, 100, 1'b0);
    build_exp(px0, W0, H0);
    cmp_words("t6", got0, 68);
    chk("t6.const", 64'(got0[68].d), 64'hFF00FF00);
`endif

    chk("mon.rd_when_empty", 64'(rd_bad), 64'(0));
    chk("mon.valid_stable", 64'(stab_bad), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
